// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: picks pop-up ovals from a free-running LFSR,
// times the up/gap/hit phases, detects hits and keeps score and miss counts.
module mole_game_ctrl #(
  parameter int unsigned GAP_TIME   = 25000000,
  parameter int unsigned UP_TIME    = 50000000,
  parameter int unsigned UP_MIN     = 12500000,
  parameter int unsigned UP_STEP    = 2500000,
  parameter int unsigned HIT_TIME   = 10000000,
  parameter int unsigned MAX_MISSES = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [4:0] btn_i,
  output logic [2:0] oval_select_o,
  output logic       mole_active_o,
  output logic       hit_flash_o,
  output logic [7:0] score_o,
  output logic [3:0] misses_o,
  output logic       game_over_o
);

  typedef enum logic [2:0] {IDLE, GAP, UP, HIT, OVER} state_e;

  localparam logic [31:0] GapLoad  = 32'(GAP_TIME - 1);
  localparam logic [31:0] HitLoad  = 32'(HIT_TIME - 1);
  localparam logic [31:0] UpInit   = 32'(UP_TIME);
  localparam logic [32:0] UpStep33 = 33'(UP_STEP);
  localparam logic [32:0] UpMin33  = 33'(UP_MIN);
  localparam logic [3:0]  MaxMiss  = 4'(MAX_MISSES);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] upLen_q, upLen_d;
  logic [2:0]  prevIdx_q, prevIdx_d;
  logic [2:0]  oval_q, oval_d;
  logic        active_q, active_d;
  logic        flash_q, flash_d;
  logic [7:0]  score_q, score_d;
  logic [3:0]  misses_q, misses_d;
  logic        over_q, over_d;

  logic [2:0]  rawIdx, popIdx;
  logic [4:0]  selMask;
  logic        hitNow;
  logic [32:0] upDiff;
  logic [31:0] shrunkLen;
  logic [7:0]  scoreInc;
  logic [3:0]  missInc;

  // Galois LFSR runs every cycle regardless of game state.
  always_comb begin
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  end

  // Fold the 3-bit random value into 0..4 and bump it if it repeats the last oval.
  always_comb begin
    rawIdx = (lfsr_q[2:0] >= 3'd5) ? (lfsr_q[2:0] - 3'd5) : lfsr_q[2:0];
    popIdx = rawIdx;
    if (rawIdx == prevIdx_q) begin
      popIdx = (rawIdx == 3'd4) ? 3'd0 : (rawIdx + 3'd1);
    end
  end

  always_comb begin
    selMask   = 5'b00001 << oval_q;
    hitNow    = |(btn_i & selMask);
    upDiff    = {1'b0, upLen_q} - UpStep33;
    shrunkLen = (upDiff[32] || (upDiff < UpMin33)) ? UpMin33[31:0] : upDiff[31:0];
    scoreInc  = (score_q == 8'hFF) ? score_q : (score_q + 8'd1);
    missInc   = misses_q + 4'd1;
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    upLen_d   = upLen_q;
    prevIdx_d = prevIdx_q;
    oval_d    = oval_q;
    active_d  = active_q;
    flash_d   = flash_q;
    score_d   = score_q;
    misses_d  = misses_q;
    over_d    = over_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = GAP;
          timer_d = GapLoad;
        end
      end
      GAP: begin
        if (timer_q == 32'd0) begin
          state_d   = UP;
          oval_d    = popIdx;
          prevIdx_d = popIdx;
          active_d  = 1'b1;
          timer_d   = upLen_q - 32'd1;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      // A hit on the final up cycle still counts as a hit.
      UP: begin
        if (hitNow) begin
          state_d = HIT;
          score_d = scoreInc;
          upLen_d = shrunkLen;
          timer_d = HitLoad;
          flash_d = 1'b1;
        end else if (timer_q == 32'd0) begin
          misses_d = missInc;
          oval_d   = 3'd7;
          active_d = 1'b0;
          if (missInc == MaxMiss) begin
            state_d = OVER;
            over_d  = 1'b1;
          end else begin
            state_d = GAP;
            timer_d = GapLoad;
          end
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      HIT: begin
        if (timer_q == 32'd0) begin
          state_d  = GAP;
          timer_d  = GapLoad;
          flash_d  = 1'b0;
          active_d = 1'b0;
          oval_d   = 3'd7;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      OVER: begin
        if (start_i) begin
          state_d   = GAP;
          timer_d   = GapLoad;
          score_d   = 8'd0;
          misses_d  = 4'd0;
          upLen_d   = UpInit;
          prevIdx_d = 3'd7;
          over_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      timer_q   <= 32'd0;
      upLen_q   <= UpInit;
      prevIdx_q <= 3'd7;
      oval_q    <= 3'd7;
      active_q  <= 1'b0;
      flash_q   <= 1'b0;
      score_q   <= 8'd0;
      misses_q  <= 4'd0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      timer_q   <= timer_d;
      upLen_q   <= upLen_d;
      prevIdx_q <= prevIdx_d;
      oval_q    <= oval_d;
      active_q  <= active_d;
      flash_q   <= flash_d;
      score_q   <= score_d;
      misses_q  <= misses_d;
      over_q    <= over_d;
    end
  end

  assign oval_select_o = oval_q;
  assign mole_active_o = active_q;
  assign hit_flash_o   = flash_q;
  assign score_o       = score_q;
  assign misses_o      = misses_q;
  assign game_over_o   = over_q;

endmodule

// File: doc/mole_game_ctrl.md
Name: mole_game_ctrl

Overview:
- Game controller directly upstream of the mole renderer; drives its oval_select (0-4).
- Decides when and where a mole pops up, using a free-running LFSR and up/gap timers.
- Takes debounced button pulses to detect hits; keeps score and miss counts; ends the game after MAX_MISSES misses.
- Outputs are registered and consumed by the renderer and the score display.

Parameters:
GAP_TIME, 25000000, cycles with no mole between pop-ups (>=2)
UP_TIME, 50000000, initial cycles a mole stays up (>=2)
UP_MIN, 12500000, floor for the shrinking up-time (>=2, <=UP_TIME)
UP_STEP, 2500000, up-time reduction per successful hit
HIT_TIME, 10000000, cycles the whacked mole stays shown before GAP (>=1)
MAX_MISSES, 3, misses that end the game (1..15)
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; starts or restarts a game
btn  in  5  debounced one-cycle pulses; bit i = oval i
oval_select  out  3  oval index 0-4 when mole_active, else 3'd7
mole_active  out  1  mole currently shown (UP or HIT)
hit_flash  out  1  high during HIT state
score  out  8  successful hits, saturating at 255
misses  out  4  timed-out moles
game_over  out  1  high in OVER state

Behaviour:
- Reset, asynchronous on rst: state=IDLE; oval_select=7; mole_active=0; hit_flash=0; score=0; misses=0; game_over=0; lfsr=LFSR_SEED; up_len=UP_TIME; timer=0; prev_idx=7.
- LFSR: 16-bit Galois, taps 16,14,13,11 (mask 16'hB400). Shifts every cycle in every state, never reloaded except by reset.
- Index generation: r=lfsr[2:0]; idx = r>=5 ? r-5 : r. If idx==prev_idx then idx=(idx+1) mod 5, so the same oval is never used twice in a row.
- State IDLE: outputs idle; start -> GAP (timer=GAP_TIME-1).
- State GAP: timer decrements each cycle; btn ignored.
  - At timer==0 -> UP. Same edge: oval_select=idx, prev_idx=idx, mole_active=1, timer=up_len-1.
- State UP: lasts exactly up_len cycles unless hit.
  - Hit = btn[oval_select]==1 in any UP cycle, regardless of other btn bits; wrong-button presses are ignored.
  - On hit -> HIT: score+1 (saturate 255), up_len=max(up_len-UP_STEP, UP_MIN), timer=HIT_TIME-1.
  - At timer==0 with no hit -> misses+1, oval_select=7, mole_active=0.
    - If the new miss count == MAX_MISSES -> OVER.
    - Otherwise -> GAP (timer=GAP_TIME-1).
  - Hit and timeout in the same cycle: hit wins.
- State HIT: hit_flash=1; mole_active=1; oval_select held.
  - At timer==0 -> GAP: hit_flash=0, mole_active=0, oval_select=7.
- State OVER: game_over=1; score and misses frozen; btn ignored.
  - start -> clear score and misses, up_len=UP_TIME, prev_idx=7, game_over=0, -> GAP.
- start in GAP/UP/HIT: ignored (no mid-game restart); only rst aborts a game.
- Latency: btn pulse to score/hit_flash update = 1 clock edge. All outputs change only on state-transition edges.
- Widths: timer 32-bit unsigned. up_len subtraction is done in 33 bits before the compare with UP_MIN, so it never underflows.

Test Plan (GAP_TIME=10, UP_TIME=20, UP_MIN=8, UP_STEP=4, HIT_TIME=5, MAX_MISSES=3):
1. Reset, start pulse, no btn -> oval_select=7 for exactly 10 cycles, then mole_active=1 for exactly 20 cycles, then misses=1, oval_select=7.
2. In UP, pulse btn[oval_select] at UP cycle 3 -> next edge score=1, hit_flash=1 for 5 cycles. Next UP lasts 16 cycles; after 3 hits UP lasts 8, and a 4th hit keeps it at 8.
3. In UP, pulse only a non-selected btn bit -> score unchanged, mole times out, misses increments.
4. Let 3 moles time out -> game_over=1, misses=3. Pulses on btn and start-free cycles change nothing. start -> score=0, misses=0, GAP resumes.
5. Run 200 pop-ups with random hits -> every oval_select while active is in 0..4, never 5-7, and never equal to the previous pop-up's index.
6. Assert rst mid-UP and mid-HIT -> all outputs at reset values immediately (asynchronously). After release, state=IDLE until start.
